reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file.sv | 61 ++++++
 tb/tb_reg_file.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, reused by the processor pipeline.
package reg_file_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file: register 0 hardwired to zero, combinational reads
// with write-through bypass, asynchronous active-low clear.
module reg_file #(
  parameter int unsigned DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_valid;

  // Writes to address 0 are dropped so that entry stays at its reset value of zero.
  assign wr_valid = write_enable && (write_reg != '0);

  // Storage array with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[write_reg] <= write_data;
    end
  end

  // Read port 1: zero during reset or at address 0, bypass on matching write.
  always_comb begin
    read_data_1 = '0;
    if (reset && (read_reg_1 != '0)) begin
      if (wr_valid && (write_reg == read_reg_1)) begin
        read_data_1 = write_data;
      end else begin
        read_data_1 = regs[read_reg_1];
      end
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    read_data_2 = '0;
    if (reset && (read_reg_2 != '0)) begin
      if (wr_valid && (write_reg == read_reg_2)) begin
        read_data_2 = write_data;
      end else begin
        read_data_2 = regs[read_reg_2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expected read values are queued
// when stimulus is applied and popped when the outputs are sampled.
module tb_reg_file;

  logic        clock;
  logic        reset;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;

  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  int          vectors;
  int          miscompares;

  reg_file dut (
    .clock        (clock),
    .reset        (reset),
    .read_reg_1   (read_reg_1),
    .read_reg_2   (read_reg_2),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    write_enable = we;
    write_reg    = wr;
    write_data   = wd;
    read_reg_1   = r1;
    read_reg_2   = r2;
  endtask

  task automatic push(input logic [31:0] e1, input logic [31:0] e2);
    exp1_q.push_back(e1);
    exp2_q.push_back(e2);
  endtask

  task automatic check(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    vectors += 2;
    if (exp1_q.size() == 0 || exp2_q.size() == 0) begin
      miscompares += 2;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e1 = exp1_q.pop_front();
      e2 = exp2_q.pop_front();
      assert (read_data_1 === e1) else begin
        miscompares++;
        $error("FAIL %s read_data_1 got %h exp %h", tag, read_data_1, e1);
      end
      assert (read_data_2 === e2) else begin
        miscompares++;
        $error("FAIL %s read_data_2 got %h exp %h", tag, read_data_2, e2);
      end
    end
  endtask

  // Sample mid-cycle, then advance to just past the next rising edge.
  task automatic sample_and_tick(input string tag);
    @(negedge clock);
    check(tag);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(1'b1, 5'd3, 32'h1111_1111, 5'd3, 5'd31);

    // In reset: writes ignored, reads zero.
    push(32'h0, 32'h0);
    sample_and_tick("in_reset");
    reset = 1'b1;

    // Write 0xA5 to r3, then read it back from storage.
    drive(1'b1, 5'd3, 32'h0000_00A5, 5'd0, 5'd0);
    push(32'h0, 32'h0);
    sample_and_tick("wr_r3");
    drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd3);
    push(32'h0000_00A5, 32'h0000_00A5);
    sample_and_tick("rd_r3");

    // Bypass on port 2 before the edge, stored value after.
    drive(1'b1, 5'd7, 32'h1234_5678, 5'd3, 5'd7);
    push(32'h0000_00A5, 32'h1234_5678);
    sample_and_tick("bypass_r7");
    drive(1'b0, 5'd7, 32'h0, 5'd3, 5'd7);
    push(32'h0000_00A5, 32'h1234_5678);
    sample_and_tick("stored_r7");

    // Register 0 ignores writes, including during the write cycle.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    push(32'h0, 32'h0);
    sample_and_tick("r0_wr_cycle");
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    push(32'h0, 32'h0);
    sample_and_tick("r0_after");

    // Incrementing sweep: port 1 via bypass, port 2 from storage.
    for (int n = 1; n < 32; n++) begin
      drive(1'b1, 5'(n), 32'(n), 5'(n), 5'(n - 1));
      push(32'(n), 32'(n - 1));
      sample_and_tick($sformatf("sweep_%0d", n));
    end
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd0);
    push(32'd31, 32'h0);
    sample_and_tick("sweep_end");

    // Same address on both ports; disabled write leaves value unchanged.
    drive(1'b1, 5'd15, 32'hDEAD_BEEF, 5'd15, 5'd15);
    push(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    sample_and_tick("r15_bypass");
    drive(1'b0, 5'd15, 32'h0, 5'd15, 5'd15);
    push(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    sample_and_tick("r15_we0");
    push(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    sample_and_tick("r15_hold");

    // Asynchronous reset between edges while writes are streaming.
    drive(1'b1, 5'd9, 32'hCAFE_0009, 5'd9, 5'd15);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    push(32'h0, 32'h0);
    check("async_rst_now");
    @(posedge clock);
    #1;
    drive(1'b1, 5'd5, 32'h5555_5555, 5'd5, 5'd20);
    push(32'h0, 32'h0);
    sample_and_tick("rst_wr_ignored");
    @(negedge clock);
    reset = 1'b1;

    // After release every register reads zero until rewritten.
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    @(posedge clock);
    #1;
    for (int a = 1; a < 32; a += 2) begin
      drive(1'b0, 5'd5, 32'hFFFF_FFFF, 5'(a), 5'(a + 1));
      push(32'h0, 32'h0);
      sample_and_tick($sformatf("post_rst_%0d", a));
    end

    // First write after release lands on the first edge.
    drive(1'b1, 5'd9, 32'h0BAD_F00D, 5'd15, 5'd1);
    push(32'h0, 32'h0);
    sample_and_tick("first_wr");
    drive(1'b0, 5'd9, 32'h0, 5'd9, 5'd9);
    push(32'h0BAD_F00D, 32'h0BAD_F00D);
    sample_and_tick("first_wr_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
